u409_tick_gen: RTL

- Parametrised 50/60Hz tick generator for U409.
- Derives two free-running square-wave ticks from the master clock by direct division; no ripple-clock chain, every flop on CLK6.
- Adds per-tick single-cycle strobes, count enable, and a glitch-free PAL/NTSC-selected tick (TICK_SEL) for the CIA TOD input.

---
 rtl/u409_tick_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/u409_tick_gen.sv
// 50/60Hz tick generator: two directly divided square waves on CLK6, rise strobes and a
// glitch-free PAL/NTSC-selected tick. Define TICK_FRAC_EN for fractional-remainder correction.
module u409_tick_gen #(
  parameter int unsigned CLK_HZ    = 6000000,
  parameter int unsigned TICK_A_HZ = 60,
  parameter int unsigned TICK_B_HZ = 50
) (
  input  logic CLK6,
  input  logic RESET,
  input  logic TICK_EN,
  input  logic PAL,
  output logic TICK60,
  output logic TICK50,
  output logic TICK60_STB,
  output logic TICK50_STB,
  output logic TICK_SEL,
  output logic TICK_SEL_STB
);

  localparam int unsigned HALF_A   = CLK_HZ / (2 * TICK_A_HZ);
  localparam int unsigned HALF_B   = CLK_HZ / (2 * TICK_B_HZ);
  localparam int unsigned HALF_MAX = (HALF_A > HALF_B) ? HALF_A : HALF_B;
  localparam int unsigned CNT_W    = $clog2(HALF_MAX + 1);

  if (HALF_A < 2 || HALF_B < 2) begin : g_bad_half
    $error("u409_tick_gen: each half period must be at least 2 clocks");
  end

  // Index 0 is channel A (TICK60), index 1 is channel B (TICK50).
  logic [1:0] lvl_q, lvl_d, stb_q;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    localparam int unsigned HALF = (ch == 0) ? HALF_A : HALF_B;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             term;
    logic             l_q, l_d, s_q, s_d;

`ifdef TICK_FRAC_EN
    localparam int unsigned MOD   = 2 * ((ch == 0) ? TICK_A_HZ : TICK_B_HZ);
    localparam int unsigned REM   = CLK_HZ % MOD;
    localparam int unsigned ACC_W = $clog2(MOD);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic             extra;

    // A half period is stretched by one clock whenever the running remainder wraps.
    always_comb begin
      sum   = {1'b0, acc_q} + (ACC_W + 1)'(REM);
      extra = (sum >= (ACC_W + 1)'(MOD));
      term  = TICK_EN && (cnt_q == (extra ? CNT_W'(HALF) : CNT_W'(HALF - 1)));
      acc_d = acc_q;
      if (term) begin
        acc_d = extra ? ACC_W'(sum - (ACC_W + 1)'(MOD)) : sum[ACC_W-1:0];
      end
    end

    always_ff @(posedge CLK6) begin
      if (RESET) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end
`else
    assign term = TICK_EN && (cnt_q == CNT_W'(HALF - 1));
`endif

    always_comb begin
      cnt_d = cnt_q;
      l_d   = l_q;
      s_d   = 1'b0;
      if (term) begin
        cnt_d = '0;
        l_d   = ~l_q;
        s_d   = ~l_q;
      end else if (TICK_EN) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge CLK6) begin
      if (RESET) begin
        cnt_q <= '0;
        l_q   <= 1'b0;
        s_q   <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        l_q   <= l_d;
        s_q   <= s_d;
      end
    end

    assign lvl_q[ch] = l_q;
    assign lvl_d[ch] = l_d;
    assign stb_q[ch] = s_q;
  end

  typedef enum logic [1:0] {StA, StB, StPendA, StPendB} sel_state_e;

  sel_state_e state_q, state_d;
  logic       sel_q, sel_d, sel_stb_q;

  // Pending states hold TICK_SEL until the target toggles onto the held level.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    if (TICK_EN) begin
      unique case (state_q)
        StA: begin
          if (PAL) state_d = StPendB;
          else     sel_d   = lvl_d[0];
        end
        StB: begin
          if (!PAL) state_d = StPendA;
          else      sel_d   = lvl_d[1];
        end
        StPendB: begin
          if (!PAL) begin
            state_d = StA;
          end else if ((lvl_d[1] != lvl_q[1]) && (lvl_d[1] == sel_q)) begin
            state_d = StB;
          end
        end
        StPendA: begin
          if (PAL) begin
            state_d = StB;
          end else if ((lvl_d[0] != lvl_q[0]) && (lvl_d[0] == sel_q)) begin
            state_d = StA;
          end
        end
        default: state_d = StA;
      endcase
    end
  end

  always_ff @(posedge CLK6) begin
    if (RESET) begin
      state_q   <= PAL ? StB : StA;
      sel_q     <= 1'b0;
      sel_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      sel_stb_q <= sel_d & ~sel_q;
    end
  end

  assign TICK60       = lvl_q[0];
  assign TICK50       = lvl_q[1];
  assign TICK60_STB   = stb_q[0];
  assign TICK50_STB   = stb_q[1];
  assign TICK_SEL     = sel_q;
  assign TICK_SEL_STB = sel_stb_q;

endmodule
